// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: decodes host commands, answers R1 and serves
// single-block reads (CMD17) from a byte-wide block memory port.
module sd_spi_card_responder #(
    parameter int unsigned NCR_BYTES    = 1,
    parameter int unsigned ACCESS_BYTES = 2,
    parameter int unsigned INIT_POLLS   = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        SD_CS,
    input  logic        SD_SCK,
    input  logic        SD_DI,
    output logic        SD_DO,
    output logic        mem_rd,
    output logic [31:0] mem_blk,
    output logic [8:0]  mem_byte,
    input  logic [7:0]  mem_data,
    output logic        card_ready,
    output logic        cmd_strobe,
    output logic [5:0]  last_cmd
);

    typedef enum logic [2:0] {HUNT, CMD_RX, NCR, RESP, GAP, TOKEN, DATA, CRC} state_t;

    localparam logic [12:0] NCR_LAST = 13'(NCR_BYTES * 8 - 1);
    localparam logic [12:0] GAP_LAST = 13'(ACCESS_BYTES * 8 - 1);

    state_t      state;
    logic [12:0] cnt;
    logic [45:0] cmd_sr;
    logic [7:0]  data_sr;
    logic [7:0]  prefetch;
    logic        rd_q;
    logic [7:0]  r1;
    logic        data_phase;
    logic        idle;
    logic        app;
    logic [3:0]  polls;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= HUNT;
            cnt        <= '0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            prefetch   <= '0;
            rd_q       <= 1'b0;
            r1         <= '0;
            data_phase <= 1'b0;
            idle       <= 1'b1;
            app        <= 1'b0;
            polls      <= '0;
            SD_DO      <= 1'b1;
            mem_rd     <= 1'b0;
            mem_blk    <= '0;
            mem_byte   <= '0;
            card_ready <= 1'b0;
            cmd_strobe <= 1'b0;
            last_cmd   <= '0;
        end else begin
            cmd_strobe <= 1'b0;
            mem_rd     <= 1'b0;
            rd_q       <= mem_rd;
            if (rd_q)
                prefetch <= mem_data;

            // cmd_sr keeps only frame bits [45:0]; decode runs the CLK after the
            // final bit, well before the first R1 tick.
            if (cmd_strobe) begin
                app        <= 1'b0;
                data_phase <= 1'b0;
                case (cmd_sr[45:40])
                    6'd0: begin
                        idle       <= 1'b1;
                        card_ready <= 1'b0;
                        polls      <= '0;
                        r1         <= 8'h01;
                    end
                    6'd55: begin
                        app <= 1'b1;
                        r1  <= {7'b0, idle};
                    end
                    6'd41: begin
                        if (!app) begin
                            r1 <= {5'b0, 1'b1, 1'b0, idle};
                        end else if (polls < 4'(INIT_POLLS)) begin
                            polls <= polls + 4'd1;
                            r1    <= 8'h01;
                        end else begin
                            idle       <= 1'b0;
                            card_ready <= 1'b1;
                            r1         <= 8'h00;
                        end
                    end
                    6'd17: begin
                        if (idle) begin
                            r1 <= 8'h05;
                        end else begin
                            r1         <= 8'h00;
                            data_phase <= 1'b1;
                        end
                    end
                    default: r1 <= {5'b0, 1'b1, 1'b0, idle};
                endcase
            end

            if (SD_CS) begin
                state <= HUNT;
                SD_DO <= 1'b1;
                cnt   <= '0;
            end else if (SD_SCK) begin
                cnt <= cnt + 13'd1;
                case (state)
                    HUNT: begin
                        SD_DO <= 1'b1;
                        if (!SD_DI) begin
                            state <= CMD_RX;
                            cnt   <= 13'd1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    CMD_RX: begin
                        SD_DO  <= 1'b1;
                        cmd_sr <= {cmd_sr[44:0], SD_DI};
                        if (cnt == 13'd47) begin
                            cmd_strobe <= 1'b1;
                            last_cmd   <= cmd_sr[44:39];
                            cnt        <= '0;
                            state      <= NCR;
                        end
                    end
                    NCR: begin
                        SD_DO <= 1'b1;
                        if (cnt == NCR_LAST) begin
                            cnt   <= '0;
                            state <= RESP;
                        end
                    end
                    RESP: begin
                        SD_DO <= r1[3'd7 - cnt[2:0]];
                        if (cnt == 13'd7) begin
                            cnt <= '0;
                            if (data_phase) begin
                                mem_blk <= cmd_sr[39:8];
                                state   <= (ACCESS_BYTES == 0) ? TOKEN : GAP;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    GAP: begin
                        SD_DO <= 1'b1;
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            state <= TOKEN;
                        end
                    end
                    TOKEN: begin
                        SD_DO <= (cnt[2:0] != 3'd7);
                        if (cnt == 13'd0) begin
                            mem_rd   <= 1'b1;
                            mem_byte <= '0;
                        end
                        if (cnt == 13'd7) begin
                            data_sr  <= prefetch;
                            mem_rd   <= 1'b1;
                            mem_byte <= mem_byte + 9'd1;
                            cnt      <= '0;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        SD_DO   <= data_sr[7];
                        data_sr <= {data_sr[6:0], 1'b0};
                        if (cnt[2:0] == 3'd7) begin
                            if (cnt[11:3] == 9'd511) begin
                                cnt   <= '0;
                                state <= CRC;
                            end else begin
                                data_sr <= prefetch;
                                if (mem_byte != 9'd511) begin
                                    mem_rd   <= 1'b1;
                                    mem_byte <= mem_byte + 9'd1;
                                end
                            end
                        end
                    end
                    CRC: begin
                        SD_DO <= 1'b1;
                        if (cnt == 13'd15) begin
                            cnt   <= '0;
                            state <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Scoreboard bench for sd_spi_card_responder: the host pushes expected SD_DO
// bytes, memory reads and command strobes; monitors pop and compare.
module tb_sd_spi_card_responder;

    localparam int unsigned NCR    = 1;
    localparam int unsigned ACCESS = 2;
    localparam int unsigned POLLS  = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        SD_CS = 1'b1;
    logic        SD_SCK = 1'b0;
    logic        SD_DI = 1'b1;
    logic        SD_DO;
    logic        mem_rd;
    logic [31:0] mem_blk;
    logic [8:0]  mem_byte;
    logic [7:0]  mem_data = 8'h00;
    logic        card_ready;
    logic        cmd_strobe;
    logic [5:0]  last_cmd;

    sd_spi_card_responder #(
        .NCR_BYTES   (NCR),
        .ACCESS_BYTES(ACCESS),
        .INIT_POLLS  (POLLS)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .SD_CS     (SD_CS),
        .SD_SCK    (SD_SCK),
        .SD_DI     (SD_DI),
        .SD_DO     (SD_DO),
        .mem_rd    (mem_rd),
        .mem_blk   (mem_blk),
        .mem_byte  (mem_byte),
        .mem_data  (mem_data),
        .card_ready(card_ready),
        .cmd_strobe(cmd_strobe),
        .last_cmd  (last_cmd)
    );

    always #5 CLK = ~CLK;

    // memory[blk][k] = k[7:0], valid one CLK after mem_rd
    always @(posedge CLK) if (mem_rd) mem_data <= mem_byte[7:0];

    typedef struct { logic [7:0] val; string tag; } exp_byte_t;
    typedef struct { logic [31:0] blk; logic [8:0] idx; } exp_rd_t;

    exp_byte_t  exp_q[$];
    exp_rd_t    rd_q[$];
    logic [5:0] cmd_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] v, input string t);
        exp_byte_t e;
        e.val = v;
        e.tag = t;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [31:0] blk, input int idx);
        exp_rd_t r;
        r.blk = blk;
        r.idx = 9'(idx);
        rd_q.push_back(r);
    endtask

    task automatic tick(input logic di);
        @(negedge CLK);
        SD_SCK = 1'b1;
        SD_DI  = di;
        @(negedge CLK);
        SD_SCK = 1'b0;
    endtask

    // ndata: 0 = no data phase, 512 = full block, else abort after ndata bytes
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            input logic [7:0] r1, input int ndata);
        logic [47:0] f;
        int rest;
        f = {2'b01, idx, arg, 8'h95};
        cmd_q.push_back(idx);
        repeat (6) push_byte(8'hFF, "cmd");
        repeat (NCR) push_byte(8'hFF, "ncr");
        push_byte(r1, "r1");
        rest = NCR + 1;
        if (ndata > 0) begin
            repeat (ACCESS) push_byte(8'hFF, "gap");
            push_byte(8'hFE, "token");
            for (int k = 0; k < ndata; k++) push_byte(8'(k), "data");
            for (int k = 0; k < ((ndata == 512) ? 512 : ndata + 2); k++) push_rd(arg, k);
            rest += ACCESS + 1 + ndata;
            if (ndata == 512) begin
                push_byte(8'hFF, "crc");
                push_byte(8'hFF, "crc");
                push_byte(8'hFF, "idle");
                rest += 3;
            end
        end else begin
            push_byte(8'hFF, "idle");
            rest += 1;
        end
        for (int i = 47; i >= 0; i--) tick(f[i]);
        repeat (rest * 8) tick(1'b1);
    endtask

    task automatic init_card();
        for (int r = 0; r < 3; r++) begin
            send_cmd(6'd55, 32'h0, 8'h01, 0);
            chk("card_ready_during_init", {31'b0, card_ready}, 32'd0);
            send_cmd(6'd41, 32'h4000_0000, (r == 2) ? 8'h00 : 8'h01, 0);
        end
        chk("card_ready_after_init", {31'b0, card_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_SD_DO", {31'b0, SD_DO}, 32'd1);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_blk", mem_blk, 32'd0);
        chk("rst_mem_byte", {23'b0, mem_byte}, 32'd0);
        chk("rst_card_ready", {31'b0, card_ready}, 32'd0);
        chk("rst_cmd_strobe", {31'b0, cmd_strobe}, 32'd0);
        chk("rst_last_cmd", {26'b0, last_cmd}, 32'd0);
    endtask

    // SD_DO byte monitor
    logic [7:0] mon_sh = 8'h00;
    int         mon_nb = 0;
    initial forever begin
        @(posedge CLK);
        if (SD_SCK && !SD_CS && !reset) begin
            #1;
            mon_sh = {mon_sh[6:0], SD_DO};
            mon_nb++;
            if (mon_nb == 8) begin
                mon_nb = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_do_byte actual=%0h expected=none", mon_sh);
                end else begin
                    exp_byte_t e;
                    e = exp_q.pop_front();
                    chk({"do_", e.tag}, {24'b0, mon_sh}, {24'b0, e.val});
                end
            end
        end
    end

    // memory-read and command-strobe monitor
    initial forever begin
        @(posedge CLK);
        #1;
        if (mem_rd) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_rd actual=%0d expected=none", mem_byte);
            end else begin
                exp_rd_t r;
                r = rd_q.pop_front();
                chk("mem_blk", mem_blk, r.blk);
                chk("mem_byte", {23'b0, mem_byte}, {23'b0, r.idx});
            end
        end
        if (cmd_strobe) begin
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd_strobe actual=%0d expected=none", last_cmd);
            end else begin
                logic [5:0] c;
                c = cmd_q.pop_front();
                chk("last_cmd", {26'b0, last_cmd}, {26'b0, c});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk_reset_outputs();

        repeat (80) tick(1'b1);
        chk("do_cs_high_preamble", {31'b0, SD_DO}, 32'd1);
        @(negedge CLK);
        SD_CS = 1'b0;

        send_cmd(6'd0, 32'h0, 8'h01, 0);
        send_cmd(6'd17, 32'h3, 8'h05, 0);
        send_cmd(6'd41, 32'h0, 8'h05, 0);
        init_card();
        send_cmd(6'd17, 32'h3, 8'h00, 512);
        chk("mem_blk_latched", mem_blk, 32'd3);
        send_cmd(6'd8, 32'h1AA, 8'h04, 0);

        // reset in the middle of a command frame
        repeat (3) push_byte(8'hFF, "cmd_partial");
        begin
            logic [47:0] f;
            f = {2'b01, 6'd0, 32'h0, 8'h95};
            for (int i = 47; i >= 24; i--) tick(f[i]);
        end
        @(negedge CLK);
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge CLK);

        send_cmd(6'd0, 32'h0, 8'h01, 0);
        init_card();

        // abort a block read with CS after 100 data bytes
        send_cmd(6'd17, 32'h7, 8'h00, 100);
        @(negedge CLK);
        SD_CS = 1'b1;
        repeat (8) tick(1'b0);
        chk("do_cs_high_abort", {31'b0, SD_DO}, 32'd1);
        chk("card_ready_kept", {31'b0, card_ready}, 32'd1);
        @(negedge CLK);
        SD_CS = 1'b0;
        push_byte(8'hFF, "resume_hunt");
        repeat (8) tick(1'b1);
        send_cmd(6'd0, 32'h0, 8'h01, 0);
        chk("card_ready_cleared", {31'b0, card_ready}, 32'd0);

        repeat (10) @(negedge CLK);
        chk("exp_do_left", exp_q.size(), 32'd0);
        chk("exp_rd_left", rd_q.size(), 32'd0);
        chk("exp_cmd_left", cmd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
